// File: rtl/console_uart_tx_pkg.sv
// console_uart_tx shared types and constants.
// FSM state encodings and the console byte width.
package console_uart_tx_pkg;

  localparam int CONSOLE_BYTE_W = 8;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Baud counter width; never below one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/console_uart_tx_if.sv
// Console write port plus UART status bundle.
// master = SoC side, slave = console_uart_tx.
interface console_uart_tx_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 16
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] console_wdata;
  logic            console_we;
  logic            tx;
  logic            busy;
  logic            overflow;
  logic [CW-1:0]   fifo_count;

  modport master (
    output console_wdata,
    output console_we,
    input  tx,
    input  busy,
    input  overflow,
    input  fifo_count
  );

  modport slave (
    input  console_wdata,
    input  console_we,
    output tx,
    output busy,
    output overflow,
    output fifo_count
  );

endinterface

// File: rtl/console_uart_tx_byte_fifo.sv
// Show-ahead synchronous byte FIFO, async reset.
// A pop on a full FIFO frees room for a same-edge push.
module console_uart_tx_byte_fifo
  import console_uart_tx_pkg::*;
#(
  parameter int WIDTH = CONSOLE_BYTE_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = wr_q - rd_q;
  assign dout    = mem[rd_q[AW-1:0]];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

  // Pointer update with extra wrap bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/console_uart_tx.sv
// Console byte sink: FIFO-buffered 8N1 UART transmitter.
// Sends byte 0 of each console write, LSB first, idle high.
module console_uart_tx
  import console_uart_tx_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic            clk,
  input  logic            reset,
  console_uart_tx_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = cnt_w(CLKS_PER_BIT);
  localparam logic [BW-1:0] CNT_MAX = BW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end

  logic [CONSOLE_BYTE_W-1:0] f_dout;
  logic [CW-1:0]             f_count;
  logic                      f_full;
  logic                      f_empty;
  logic                      pop;
  logic                      bit_end;

  uart_state_e               state_q;
  logic [BW-1:0]             cnt_q;
  logic [2:0]                bit_q;
  logic [CONSOLE_BYTE_W-1:0] shift_q;
  logic                      tx_q;
  logic                      ovf_q;

  logic                      unused_hi;
  assign unused_hi = ^bus.console_wdata[XLEN-1:CONSOLE_BYTE_W];

  console_uart_tx_byte_fifo #(
    .WIDTH (CONSOLE_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.console_we),
    .din   (bus.console_wdata[CONSOLE_BYTE_W-1:0]),
    .pop   (pop),
    .dout  (f_dout),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty)
  );

  assign bit_end = (cnt_q == CNT_MAX);
  assign pop     = ~f_empty &
                   ((state_q == UART_IDLE) |
                    ((state_q == UART_STOP) & bit_end));

  // Frame sequencer: start, 8 data bits, stop, chained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        UART_IDLE: begin
          cnt_q <= '0;
          if (pop) begin
            shift_q <= f_dout;
            tx_q    <= 1'b0;
            state_q <= UART_START;
          end
        end
        UART_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= UART_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        UART_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= UART_STOP;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        UART_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (pop) begin
              shift_q <= f_dout;
              tx_q    <= 1'b0;
              state_q <= UART_START;
            end else begin
              state_q <= UART_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Sticky drop flag: push on a full FIFO with no pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (bus.console_we & f_full & ~pop) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_count = f_count;
  assign bus.busy       = (state_q != UART_IDLE) | (f_count != '0);

endmodule
